// File: rtl/flash_bridge.sv
`default_nettype none
// ============================================================================
// flash_bridge : host strobe bus to ticked flash request/acknowledge bridge
// rev 1.0
// ============================================================================
module flash_bridge #(
  parameter int DIV     = 8,
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              n_AS,
  input  logic              n_DS,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA_IN,
  input  logic [3:0]        BE,
  input  logic              RD,
  input  logic              WR,
  output logic [31:0]       DATA_OUT,
  output logic              Term,
  output logic              ERR,
  output logic              FL_TICK,
  output logic [ADDR_W-1:0] FL_ADDR,
  output logic [31:0]       FL_WDATA,
  output logic [3:0]        FL_BE,
  output logic              FL_RD,
  output logic              FL_WR,
  input  logic [31:0]       FL_RDATA,
  input  logic              FL_ACK
);

  localparam logic [7:0]  TICK_LAST = 8'(DIV - 1);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  logic [7:0]        tick_cnt_q;
  logic [7:0]        tick_cnt_d;
  logic              tick_q;
  logic [15:0]       tmo_q;
  logic [15:0]       tmo_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              dir_rd_q;
  logic              abort_q;
  logic              term_q;
  logic              err_q;
  logic [31:0]       dout_q;
  logic [ADDR_W-1:0] fl_addr_q;
  logic [31:0]       fl_wdata_q;
  logic [3:0]        fl_be_q;
  logic              fl_rd_q;
  logic              fl_wr_q;

  logic strobes;
  logic start_req;
  logic conflict;
  logic host_gone;

  assign strobes   = !n_AS && !n_DS;
  assign start_req = strobes && (RD ^ WR);
  assign conflict  = strobes && RD && WR;
  // Host released the address strobe at any point during the flash handshake.
  assign host_gone = abort_q || n_AS;

  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? 8'd0 : tick_cnt_q + 8'd1;
    tmo_d      = tmo_q + 16'd1;
  end

  // tick_q is asserted exactly while the counter sits at DIV-1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_cnt_q <= 8'd0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= (tick_cnt_d == TICK_LAST);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      tmo_q      <= 16'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      dir_rd_q   <= 1'b0;
      abort_q    <= 1'b0;
      term_q     <= 1'b0;
      err_q      <= 1'b0;
      dout_q     <= 32'd0;
      fl_addr_q  <= '0;
      fl_wdata_q <= 32'd0;
      fl_be_q    <= 4'd0;
      fl_rd_q    <= 1'b0;
      fl_wr_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (conflict) begin
            state_q <= S_DONE;
            term_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (start_req) begin
            state_q <= S_LATCH;
          end
        end

        S_LATCH: begin
          addr_q   <= ADDR;
          wdata_q  <= DATA_IN;
          be_q     <= BE;
          dir_rd_q <= RD;
          // No enabled bytes: finish locally without touching the flash.
          if (BE == 4'b0000) begin
            if (host_gone) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DONE;
              term_q  <= 1'b1;
              err_q   <= 1'b0;
            end
          end else begin
            abort_q <= host_gone;
            state_q <= S_REQ;
          end
        end

        S_REQ: begin
          abort_q <= host_gone;
          if (tick_q) begin
            fl_addr_q  <= addr_q;
            fl_wdata_q <= wdata_q;
            fl_be_q    <= be_q;
            fl_rd_q    <= dir_rd_q;
            fl_wr_q    <= !dir_rd_q;
            tmo_q      <= 16'd0;
            state_q    <= S_WAIT;
          end
        end

        S_WAIT: begin
          abort_q <= host_gone;
          if (tick_q) begin
            fl_rd_q <= 1'b0;
            fl_wr_q <= 1'b0;
            if (FL_ACK) begin
              if (dir_rd_q) begin
                dout_q <= FL_RDATA;
              end
              if (host_gone) begin
                state_q <= S_IDLE;
              end else begin
                state_q <= S_DONE;
                term_q  <= 1'b1;
                err_q   <= 1'b0;
              end
            end else if (tmo_d == TMO_LIMIT) begin
              tmo_q <= tmo_d;
              if (host_gone) begin
                state_q <= S_IDLE;
              end else begin
                state_q <= S_DONE;
                term_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            end else begin
              tmo_q <= tmo_d;
            end
          end
        end

        S_DONE: begin
          if (n_AS) begin
            term_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign DATA_OUT = dout_q;
  assign Term     = term_q;
  assign ERR      = err_q;
  assign FL_TICK  = tick_q;
  assign FL_ADDR  = fl_addr_q;
  assign FL_WDATA = fl_wdata_q;
  assign FL_BE    = fl_be_q;
  assign FL_RD    = fl_rd_q;
  assign FL_WR    = fl_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_bridge.sv
`default_nettype none
// ============================================================================
// tb_flash_bridge : randomized self-checking bench with a cycle-level model
// rev 1.0
// ============================================================================
module tb_flash_bridge;

  localparam int DIV     = 8;
  localparam int ADDR_W  = 24;
  localparam int TIMEOUT = 4;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              n_AS = 1'b1;
  logic              n_DS = 1'b1;
  logic [ADDR_W-1:0] ADDR = '0;
  logic [31:0]       DATA_IN = 32'd0;
  logic [3:0]        BE = 4'd0;
  logic              RD = 1'b0;
  logic              WR = 1'b0;
  logic [31:0]       DATA_OUT;
  logic              Term;
  logic              ERR;
  logic              FL_TICK;
  logic [ADDR_W-1:0] FL_ADDR;
  logic [31:0]       FL_WDATA;
  logic [3:0]        FL_BE;
  logic              FL_RD;
  logic              FL_WR;
  logic [31:0]       FL_RDATA = 32'd0;
  logic              FL_ACK = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] dout_m = 32'd0;

  flash_bridge #(.DIV(DIV), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .n_AS(n_AS), .n_DS(n_DS), .ADDR(ADDR),
    .DATA_IN(DATA_IN), .BE(BE), .RD(RD), .WR(WR), .DATA_OUT(DATA_OUT),
    .Term(Term), .ERR(ERR), .FL_TICK(FL_TICK), .FL_ADDR(FL_ADDR),
    .FL_WDATA(FL_WDATA), .FL_BE(FL_BE), .FL_RD(FL_RD), .FL_WR(FL_WR),
    .FL_RDATA(FL_RDATA), .FL_ACK(FL_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Cycle index restarts at 0 right after the last reset edge; ticks fall on DIV-1, 2*DIV-1, ...
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    check("fl_tick", FL_TICK, 64'((cyc % DIV) == DIV - 1));
  endtask

  task automatic do_reset();
    RST    = 1'b1;
    FL_ACK = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_fl_rd", FL_RD, 0);
    check("rst_fl_wr", FL_WR, 0);
    check("rst_term", Term, 0);
    check("rst_err", ERR, 0);
    check("rst_tick", FL_TICK, 0);
    check("rst_dout", DATA_OUT, 0);
    check("rst_fl_addr", FL_ADDR, 0);
    check("rst_fl_wdata", FL_WDATA, 0);
    check("rst_fl_be", FL_BE, 0);
    RST    = 1'b0;
    cyc    = 0;
    dout_m = 32'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_term", Term, 0);
      check("idle_fl_rd", FL_RD, 0);
      check("idle_fl_wr", FL_WR, 0);
      check("idle_dout", DATA_OUT, dout_m);
      FL_ACK   = 1'($urandom);
      FL_RDATA = $urandom;
    end
  endtask

  // kind: 0 read, 1 write, 2 RD+WR conflict. ack_tick: WAIT tick carrying FL_ACK (0 = never).
  task automatic txn(input int kind, input int ack_tick, input bit abort_in,
                     input logic [ADDR_W-1:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] rdat);
    int c0, req_cyc, term_cyc, end_cyc, k;
    bit has_req, is_rd, ok, ab, req_on, term_on;
    is_rd    = (kind == 0);
    has_req  = (kind != 2) && (be != 4'd0);
    ok       = (kind != 2) && (!has_req || (ack_tick >= 1 && ack_tick <= TIMEOUT));
    ab       = abort_in && has_req;
    c0       = cyc;
    req_cyc  = -1000;
    if (kind == 2) begin
      term_cyc = c0 + 1;
    end else if (!has_req) begin
      term_cyc = c0 + 2;
    end else begin
      req_cyc = c0 + 2;
      while (req_cyc % DIV != DIV - 1) req_cyc++;
      req_cyc++;
      term_cyc = req_cyc - 1 + (ok ? ack_tick : TIMEOUT) * DIV + 1;
    end
    end_cyc = ab ? term_cyc + 2 : term_cyc + $urandom_range(0, 3);

    n_AS = 1'b0; n_DS = 1'b0;
    RD = (kind != 1); WR = (kind != 0);
    ADDR = a; DATA_IN = d; BE = be;
    while (cyc < end_cyc) begin
      step();
      if (cyc >= c0 + 2) begin
        ADDR    = ADDR_W'($urandom);
        DATA_IN = $urandom;
        BE      = 4'($urandom);
      end
      if (ab && cyc == req_cyc + 2) n_AS = 1'b1;
      req_on  = has_req && cyc >= req_cyc && cyc < req_cyc + DIV;
      term_on = !ab && cyc >= term_cyc;
      check("fl_rd", FL_RD, 64'(req_on && is_rd));
      check("fl_wr", FL_WR, 64'(req_on && !is_rd));
      if (has_req && cyc == req_cyc) begin
        check("fl_addr", FL_ADDR, a);
        check("fl_wdata", FL_WDATA, d);
        check("fl_be", FL_BE, be);
      end
      check("term", Term, 64'(term_on));
      if (term_on) check("err", ERR, 64'(!ok));
      if (cyc >= term_cyc && is_rd && ok && has_req) dout_m = rdat;
      check("data_out", DATA_OUT, dout_m);
      FL_ACK   = 1'($urandom);
      FL_RDATA = $urandom;
      if (has_req && cyc >= req_cyc && cyc < term_cyc && (cyc - (req_cyc - 1)) % DIV == 0) begin
        k      = (cyc - (req_cyc - 1)) / DIV;
        FL_ACK = (k == ack_tick);
        if (k == ack_tick) FL_RDATA = rdat;
      end
    end
    n_AS = 1'b1; n_DS = 1'b1; RD = 1'b0; WR = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rel_term", Term, 0);
      check("rel_err", ERR, 0);
      check("rel_dout", DATA_OUT, dout_m);
      FL_ACK = 1'($urandom);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    bit seen;
    int kind, ackt;
    logic [3:0] be;
    do_reset();
    idle(3);

    txn(0, 2, 1'b0, 24'h000010, 32'h0, 4'b1111, 32'hDEADBEEF);
    idle(2);
    txn(1, 1, 1'b0, ADDR_W'($urandom), 32'h12345678, 4'b0011, 32'hCAFEF00D);
    txn(0, 0, 1'b0, ADDR_W'($urandom), $urandom, 4'b1111, 32'h11111111);
    txn(2, 1, 1'b0, ADDR_W'($urandom), $urandom, 4'b1111, 32'h0);
    txn(0, 2, 1'b1, ADDR_W'($urandom), $urandom, 4'b0101, 32'hA5A5A5A5);
    txn(0, 1, 1'b0, ADDR_W'($urandom), $urandom, 4'b1000, 32'h5A5A5A5A);
    txn(1, 1, 1'b0, ADDR_W'($urandom), $urandom, 4'b0000, 32'h0);
    txn(0, 1, 1'b0, ADDR_W'($urandom), $urandom, 4'b0000, 32'h77777777);

    // Reset while a read is outstanding in WAIT.
    n_AS = 1'b0; n_DS = 1'b0; RD = 1'b1; WR = 1'b0;
    ADDR = ADDR_W'($urandom); BE = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      FL_ACK = 1'b0;
      if (FL_RD) seen = 1'b1;
    end
    check("rst_req_seen", 64'(seen), 1);
    step();
    step();
    do_reset();
    n_AS = 1'b1; n_DS = 1'b1; RD = 1'b0;
    idle(2 * DIV + 1);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      kind = (kind < 4) ? 0 : (kind < 7) ? 1 : (kind < 9) ? 0 : 2;
      be   = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      ackt = $urandom_range(0, 6);
      txn(kind, ackt, ($urandom_range(0, 5) == 0), ADDR_W'($urandom), $urandom, be, $urandom);
      idle($urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
